fp_decode: RTL

FP_DECODE -- requirements
Module: fp_decode

---
 rtl/fp_decode.sv | 102 ++++++++++
 1 files changed

// File: rtl/fp_decode.sv
// rtl/fp_decode.sv - 8-bit float {S,E[2:0],F[3:0]} to 12-bit two's-complement linear converter
// Build option FPDEC_EARLY_EXIT_EN: leave SHIFT as soon as cnt reaches 0 instead of after 8 edges.
module fp_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_fp,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [11:0] out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, SIGN, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [10:0] mag;
  logic [2:0]  cnt;
  logic        sgn;
  logic        shift_last;

`ifdef FPDEC_EARLY_EXIT_EN
  assign shift_last = (cnt == 3'd0);
`else
  // Counts SHIFT edges so every exponent sees the same 8-edge latency.
  logic [2:0] tick;
  assign shift_last = (tick == 3'd7);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (shift_last) state_nxt = SIGN;
      end
      SIGN: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag  <= 11'd0;
      cnt  <= 3'd0;
      sgn  <= 1'b0;
      out  <= 12'd0;
`ifndef FPDEC_EARLY_EXIT_EN
      tick <= 3'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag  <= {7'd0, in_fp[3:0]};
            cnt  <= in_fp[6:4];
            sgn  <= in_fp[7];
`ifndef FPDEC_EARLY_EXIT_EN
            tick <= 3'd0;
`endif
          end
        end
        SHIFT: begin
          if (cnt != 3'd0) begin
            mag <= mag << 1;
            cnt <= cnt - 3'd1;
          end
`ifndef FPDEC_EARLY_EXIT_EN
          tick <= tick + 3'd1;
`endif
        end
        SIGN: begin
          // Negative zero falls out naturally: 0 - 0 = 0.
          out <= sgn ? (12'd0 - {1'b0, mag}) : {1'b0, mag};
        end
        default: ;
      endcase
    end
  end

endmodule
